// File: rtl/neuron_acc_seq_if.sv
// Stream, MAC-operand and status bundle for neuron_acc_seq.
//
// Signals:
//   start, bias                 - begin a neuron, initial accumulator value
//   in_valid/in_ready/in_x/in_w - input/weight pair stream
//   mac_x/mac_w/mac_b           - operands driven to the external combinational MAC
//   mac_result                  - MAC output (mac_b + mac_x*mac_w, truncated)
//   out_valid/out_ready/out_data - neuron result stream
//   busy                        - block is not idle
//
// Modports: master is the environment side (producer, MAC and consumer); slave is
// the neuron controller.
interface neuron_acc_seq_if #(
  parameter int W = 8
);
  logic                start;
  logic signed [W-1:0] bias;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_x;
  logic signed [W-1:0] in_w;
  logic signed [W-1:0] mac_x;
  logic signed [W-1:0] mac_w;
  logic signed [W-1:0] mac_b;
  logic signed [W-1:0] mac_result;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic                busy;

  modport master (
    output start, bias, in_valid, in_x, in_w, mac_result, out_ready,
    input  in_ready, mac_x, mac_w, mac_b, out_valid, out_data, busy
  );

  modport slave (
    input  start, bias, in_valid, in_x, in_w, mac_result, out_ready,
    output in_ready, mac_x, mac_w, mac_b, out_valid, out_data, busy
  );
endinterface

// File: rtl/neuron_acc_seq.sv
// Sequential neuron controller wrapped around an external combinational MAC.
//
// On start (IDLE only) the accumulator is loaded with bias; each accepted input pair
// replaces the accumulator with the MAC result, whose bias operand is the accumulator
// itself. After N_INPUTS pairs the result is presented on a valid/ready output.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   bus (slave) - start/bias, input pair stream, MAC operands/result, output stream, busy
//
// Build option: define NEURON_RELU_EN to clamp negative results to zero (ReLU);
// otherwise the accumulator is output unchanged. Timing is identical in both builds.
module neuron_acc_seq #(
  parameter int INTE_WIDTH = 2,
  parameter int SIGN_BIT   = 1,
  parameter int FRAC_WIDTH = 5,
  parameter int N_INPUTS   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  neuron_acc_seq_if.slave bus
);

  localparam int W  = SIGN_BIT + INTE_WIDTH + FRAC_WIDTH;
  localparam int CW = $clog2(N_INPUTS + 1);

  localparam logic [CW-1:0] LastCnt = CW'(N_INPUTS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                beat;

  // in_ready is exactly "state is ACC", so a beat needs only in_valid there.
  assign beat = (state_q == StAcc) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = bus.bias;
          cnt_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (beat) begin
          acc_d = bus.mac_result;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        // start is not looked at here, so a start coinciding with the handshake is dropped.
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // MAC operands: pair passes straight through, running sum is fed back as bias.
  assign bus.mac_x = bus.in_x;
  assign bus.mac_w = bus.in_w;
  assign bus.mac_b = acc_q;

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StOut);
  assign bus.busy      = (state_q != StIdle);

  // Output comes from registers only; it reads zero outside OUT.
`ifdef NEURON_RELU_EN
  assign bus.out_data = ((state_q == StOut) && !acc_q[W-1]) ? acc_q : '0;
`else
  assign bus.out_data = (state_q == StOut) ? acc_q : '0;
`endif

endmodule

// File: tb/tb_neuron_acc_seq.sv
module tb_neuron_acc_seq;

  localparam int INTE_WIDTH = 2;
  localparam int SIGN_BIT   = 1;
  localparam int FRAC_WIDTH = 5;
  localparam int N_INPUTS   = 4;
  localparam int W          = SIGN_BIT + INTE_WIDTH + FRAC_WIDTH;
  localparam int MaxWait    = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic signed [W-1:0] xs [N_INPUTS];
  logic signed [W-1:0] ws [N_INPUTS];
  logic signed [W-1:0] got;

  neuron_acc_seq_if #(.W(W)) bus ();

  neuron_acc_seq #(
    .INTE_WIDTH (INTE_WIDTH),
    .SIGN_BIT   (SIGN_BIT),
    .FRAC_WIDTH (FRAC_WIDTH),
    .N_INPUTS   (N_INPUTS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: b + x*w with the fractional part truncated, wrapping to W bits.
  assign bus.mac_result =
      W'(int'(bus.mac_b) + ((int'(bus.mac_x) * int'(bus.mac_w)) >>> FRAC_WIDTH));

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [W-1:0] mac_step(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] w);
    return W'(int'(a) + ((int'(x) * int'(w)) >>> FRAC_WIDTH));
  endfunction

  function automatic logic signed [W-1:0] expect_out(input logic signed [W-1:0] b);
    logic signed [W-1:0] a;
    a = b;
    for (int i = 0; i < N_INPUTS; i++) a = mac_step(a, xs[i], ws[i]);
`ifdef NEURON_RELU_EN
    if (a < 0) a = '0;
`endif
    return a;
  endfunction

  // Runs one neuron starting at the current negedge; ends on the negedge after the
  // output handshake, so a following call restarts immediately (back-to-back).
  task automatic run_neuron(input logic signed [W-1:0] b, input int gap, input int ostall,
                            input bit noise, output logic signed [W-1:0] res);
    logic signed [W-1:0] acc_m;
    logic signed [W-1:0] exp_out;
    int cyc;
    acc_m   = b;
    exp_out = expect_out(b);
    check("idle_busy", int'(bus.busy), 0);
    bus.start = 1'b1;
    bus.bias  = b;
    @(negedge clk);
    cyc = 1;
    bus.start = 1'b0;
    check("acc_busy", int'(bus.busy), 1);
    check("acc_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < N_INPUTS; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          bus.in_x     = W'($urandom);
          bus.in_w     = W'($urandom);
          bus.start    = noise;
          bus.bias     = W'($urandom);
          @(negedge clk);
          cyc++;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_x     = xs[i];
      bus.in_w     = ws[i];
      bus.start    = noise;
      check("mac_b", int'(bus.mac_b), int'(acc_m));
      acc_m = mac_step(acc_m, xs[i], ws[i]);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    while (!bus.out_valid && cyc < MaxWait) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, N_INPUTS + 1 + gap * (N_INPUTS - 1));
    check("out_valid", int'(bus.out_valid), 1);
    check("out_in_ready", int'(bus.in_ready), 0);
    check("out_data", int'(bus.out_data), int'(exp_out));
    res = bus.out_data;
    for (int s = 0; s < ostall; s++) begin
      bus.out_ready = 1'b0;
      bus.start     = noise;
      @(negedge clk);
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_data", int'(bus.out_data), int'(exp_out));
    end
    // start during the handshake cycle must be ignored
    bus.out_ready = 1'b1;
    bus.start     = noise;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("done_valid", int'(bus.out_valid), 0);
    check("done_busy", int'(bus.busy), 0);
  endtask

  task automatic set_pairs(input logic signed [W-1:0] x, input logic signed [W-1:0] w);
    for (int i = 0; i < N_INPUTS; i++) begin
      xs[i] = x;
      ws[i] = w;
    end
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_in_ready"}, int'(bus.in_ready), 0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_data"}, int'(bus.out_data), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_mac_b"}, int'(bus.mac_b), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_w      = '0;
    bus.out_ready = 1'b0;
    #1;
    check_zeroed("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: 4 x (1.0 * 0.5) -> 2.0
    set_pairs(W'(8'h20), W'(8'h10));
    run_neuron(W'(8'h00), 0, 0, 1'b0, got);
    check("basic_const", int'(got), 64);

    // Negative sum, back-to-back with the previous neuron
    set_pairs(W'(8'hE0), W'(8'h20));
    run_neuron(W'(8'h00), 0, 0, 1'b0, got);
`ifdef NEURON_RELU_EN
    check("neg_const", int'(got), 0);
`else
    check("neg_const", int'(got), -128);
`endif

    // Bias only: weights zero
    for (int i = 0; i < N_INPUTS; i++) begin
      xs[i] = W'($urandom);
      ws[i] = '0;
    end
    run_neuron(W'(8'h10), 0, 0, 1'b0, got);
    check("bias_const", int'(got), 16);

    // Stalls on input and output, with stray start pulses
    set_pairs(W'(8'h20), W'(8'h10));
    run_neuron(W'(8'h00), 2, 3, 1'b1, got);
    check("stall_const", int'(got), 64);

    // Reset after two accepted beats
    bus.start = 1'b1;
    bus.bias  = W'(8'h33);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = W'($urandom);
      bus.in_w     = W'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zeroed("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_pairs(W'(8'h20), W'(8'h10));
    run_neuron(W'(8'h00), 0, 0, 1'b0, got);
    check("post_rst_const", int'(got), 64);

    // Randomized neurons
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        xs[i] = W'($urandom);
        ws[i] = W'($urandom);
      end
      run_neuron(W'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
